fact_accel: RTL

//  Memory-mapped iterative factorial accelerator on the mips_top data-memory bus, downstream of the core.
//  The core stores n, writes GO, polls STATUS, then loads RESULT with lw/sw.
//  The SoC address decoder drives sel and forwards addr[3:2], we_dm and wd_dm.
//  rd feeds the read-data mux back to the core.

---
 rtl/fact_pkg.sv | 19 +
 rtl/fact_dp.sv | 39 +++
 rtl/fact_accel.sv | 110 +++++++++++
 3 files changed

// File: rtl/fact_pkg.sv
// Shared definitions for the memory-mapped factorial accelerator:
// register offsets, FSM state encoding and STATUS bit positions.
package fact_pkg;

    localparam logic [1:0] REG_N      = 2'd0;
    localparam logic [1:0] REG_GO     = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RESULT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DONE_BIT = 0;
    localparam int ERR_BIT  = 1;

endpackage

// File: rtl/fact_dp.sv
// Iterative factorial datapath: down-counter, running product and the
// end-of-iteration compare.
module fact_dp #(
    parameter int DATA_W = 32,
    parameter int N_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [N_W-1:0]    n,
    output logic [DATA_W-1:0] prod,
    output logic              last
);

    logic [N_W-1:0] cnt;

    // The cnt<=1 compare is registered so the multiplier output never feeds
    // the FSM decision directly; this costs exactly one cycle per job, and
    // the multiply is suppressed once cnt<=1 so n=0 still yields 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            prod <= '0;
            last <= 1'b0;
        end else if (load) begin
            cnt  <= n;
            prod <= DATA_W'(1);
            last <= 1'b0;
        end else if (step) begin
            last <= (cnt <= N_W'(1));
            if (cnt > N_W'(1)) begin
                prod <= prod * DATA_W'(cnt);
                cnt  <= cnt - N_W'(1);
            end
        end
    end

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: register file, write decode, control
// FSM and combinational read mux around the fact_dp datapath.
module fact_accel
    import fact_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 4,
    parameter int MAX_N  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    state_t            state;
    logic [N_W-1:0]    n_reg;
    logic [DATA_W-1:0] result;
    logic              done;
    logic              err;

    logic              wr;
    logic              start;
    logic              n_too_big;
    logic              busy;
    logic              load;
    logic              step;
    logic [DATA_W-1:0] prod;
    logic              last;
    logic              unused_wd_bits;

    assign unused_wd_bits = ^wd[DATA_W-1:N_W];

    assign wr        = sel && we;
    assign start     = wr && (a == REG_GO) && wd[0];
    assign n_too_big = int'(n_reg) > MAX_N;
    assign busy      = (state == BUSY);
    assign load      = start && !busy && !n_too_big;
    assign step      = busy;

    fact_dp #(
        .DATA_W (DATA_W),
        .N_W    (N_W)
    ) u_dp (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .n    (n_reg),
        .prod (prod),
        .last (last)
    );

    // n_reg may be rewritten at any time; the datapath already holds its
    // own copy of the count, so a job in flight is unaffected.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            n_reg  <= '0;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (wr && (a == REG_N)) begin
                n_reg <= wd[N_W-1:0];
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        result <= '0;
                        if (n_too_big) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= BUSY;
                            done  <= 1'b0;
                            err   <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (last) begin
                        state  <= DONE;
                        result <= prod;
                        done   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd = '0;
        case (a)
            REG_N:      rd = DATA_W'(n_reg);
            REG_GO:     rd[0] = busy;
            REG_STATUS: begin
                rd[DONE_BIT] = done;
                rd[ERR_BIT]  = err;
            end
            default:    rd = result;
        endcase
    end

endmodule
